// File: rtl/db_pkg.sv
// Shared encodings for the on-chip set-associative key/value table.
package db_pkg;

  localparam logic [3:0] OP_GET   = 4'b0000;
  localparam logic [3:0] OP_PUT   = 4'b0011;
  localparam logic [3:0] OP_DEL   = 4'b0101;
  localparam logic [3:0] OP_FLUSH = 4'b1111;

  localparam int unsigned FLAG_HIT     = 0;
  localparam int unsigned FLAG_WRITTEN = 1;
  localparam int unsigned FLAG_EVICTED = 2;
  localparam int unsigned FLAG_ERR     = 3;

  typedef enum logic [1:0] {StInit, StIdle, StLook, StResp} state_e;

  // Entry layout at the default widths; the RAM packs {valid, key, value} in this order.
  typedef struct packed {
    logic        valid;
    logic [95:0] key;
    logic [31:0] value;
  } entry_t;

endpackage

// File: rtl/db_way_ram.sv
// One way of the table: single-port RAM of {valid, key, value}, one-cycle synchronous read.
module db_way_ram #(
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned KEY_SIZE = 96,
  parameter int unsigned VAL_SIZE = 32
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [IDX_BITS-1:0] i_addr,
  input  logic                i_valid,
  input  logic [KEY_SIZE-1:0] i_key,
  input  logic [VAL_SIZE-1:0] i_value,
  output logic                o_valid,
  output logic [KEY_SIZE-1:0] o_key,
  output logic [VAL_SIZE-1:0] o_value
);

  localparam int unsigned Depth = 1 << IDX_BITS;
  localparam int unsigned Width = 1 + KEY_SIZE + VAL_SIZE;

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rd;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= {i_valid, i_key, i_value};
    end else begin
      r_rd <= r_mem[i_addr];
    end
  end

  assign {o_valid, o_key, o_value} = r_rd;

endmodule

// File: rtl/db_cont_mw.sv
// N-way set-associative key/value table with GET/PUT/DEL/FLUSH, ready/valid input
// and a registered one-cycle response strobe.
module db_cont_mw
  import db_pkg::*;
#(
  parameter int unsigned HASH_SIZE = 32,
  parameter int unsigned KEY_SIZE  = 96,
  parameter int unsigned VAL_SIZE  = 32,
  parameter int unsigned FLAG_SIZE = 4,
  parameter int unsigned IDX_BITS  = 8,
  parameter int unsigned WAYS      = 4,
  parameter int unsigned EVICT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [HASH_SIZE-1:0] in_hash,
  input  logic [KEY_SIZE-1:0]  in_key,
  input  logic [VAL_SIZE-1:0]  in_value,
  output logic                 out_valid,
  output logic [FLAG_SIZE-1:0] out_flag,
  output logic [VAL_SIZE-1:0]  out_value
);

  localparam int unsigned WayBits = $clog2(WAYS);

  state_e                r_state, w_state_nxt;
  logic [IDX_BITS-1:0]   r_cnt, r_idx, w_addr;
  logic [3:0]            r_op;
  logic [KEY_SIZE-1:0]   r_key;
  logic [VAL_SIZE-1:0]   r_val;
  logic [WayBits-1:0]    r_victim;
  logic [WAYS-1:0]       r_we, w_we, w_we_look;
  logic                  r_wr_valid, w_wr_valid, w_wr_valid_look;
  logic [VAL_SIZE-1:0]   r_wr_val, w_wr_val_look;
  logic [FLAG_SIZE-1:0]  r_resp_flag, w_flag_look, r_out_flag;
  logic [VAL_SIZE-1:0]   r_resp_val, w_val_look, r_out_value;
  logic                  r_out_valid, w_victim_adv;
  logic                  w_any_hit, w_any_free;
  logic [WayBits-1:0]    w_hit_way, w_free_way;
  logic [WAYS-1:0]       w_rd_valid;
  logic [KEY_SIZE-1:0]   w_rd_key [WAYS];
  logic [VAL_SIZE-1:0]   w_rd_val [WAYS];
  logic                  w_unused_hash;

  assign w_unused_hash = ^in_hash[HASH_SIZE-1:IDX_BITS];

  // RAM port: init sweep, lookup read on accept, or write-back in RESP.
  always_comb begin
    w_addr     = r_idx;
    w_we       = '0;
    w_wr_valid = 1'b0;
    unique case (r_state)
      StInit: begin
        w_addr = r_cnt;
        w_we   = '1;
      end
      StIdle: w_addr = in_hash[IDX_BITS-1:0];
      StResp: begin
        w_we       = r_we;
        w_wr_valid = r_wr_valid;
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    db_way_ram #(
      .IDX_BITS (IDX_BITS),
      .KEY_SIZE (KEY_SIZE),
      .VAL_SIZE (VAL_SIZE)
    ) u_ram (
      .clk     (clk),
      .i_we    (w_we[g]),
      .i_addr  (w_addr),
      .i_valid (w_wr_valid),
      .i_key   (r_key),
      .i_value (r_wr_val),
      .o_valid (w_rd_valid[g]),
      .o_key   (w_rd_key[g]),
      .o_value (w_rd_val[g])
    );
  end

  // Descending scan so the lowest-index match is the one left standing.
  always_comb begin
    w_any_hit  = 1'b0;
    w_hit_way  = '0;
    w_any_free = 1'b0;
    w_free_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_rd_valid[i] && (w_rd_key[i] == r_key)) begin
        w_any_hit = 1'b1;
        w_hit_way = WayBits'(i);
      end
      if (!w_rd_valid[i]) begin
        w_any_free = 1'b1;
        w_free_way = WayBits'(i);
      end
    end
  end

  always_comb begin
    w_we_look       = '0;
    w_wr_valid_look = 1'b0;
    w_wr_val_look   = r_val;
    w_flag_look     = '0;
    w_val_look      = '0;
    w_victim_adv    = 1'b0;
    case (r_op)
      OP_GET: begin
        if (w_any_hit) begin
          w_flag_look[FLAG_HIT] = 1'b1;
          w_val_look            = w_rd_val[w_hit_way];
        end
      end
      OP_PUT: begin
        w_wr_valid_look           = 1'b1;
        w_flag_look[FLAG_WRITTEN] = 1'b1;
        if (w_any_hit) begin
          w_we_look[w_hit_way]  = 1'b1;
          w_flag_look[FLAG_HIT] = 1'b1;
          w_val_look            = w_rd_val[w_hit_way];
        end else if (w_any_free) begin
          w_we_look[w_free_way] = 1'b1;
        end else if (EVICT != 0) begin
          w_we_look[r_victim]       = 1'b1;
          w_flag_look[FLAG_EVICTED] = 1'b1;
          w_val_look                = w_rd_val[r_victim];
          w_victim_adv              = 1'b1;
        end else begin
          w_flag_look               = '0;
          w_flag_look[FLAG_ERR]     = 1'b1;
        end
      end
      OP_DEL: begin
        if (w_any_hit) begin
          w_we_look[w_hit_way]  = 1'b1;
          w_flag_look[FLAG_HIT] = 1'b1;
          w_val_look            = w_rd_val[w_hit_way];
        end
      end
      default: w_flag_look[FLAG_ERR] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StInit;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StInit: if (&r_cnt) w_state_nxt = StIdle;
      StIdle: if (in_valid) w_state_nxt = (in_op == OP_FLUSH) ? StInit : StLook;
      StLook: w_state_nxt = StResp;
      StResp: w_state_nxt = StIdle;
      default: w_state_nxt = StInit;
    endcase
  end

  always_comb begin
    in_ready = (r_state == StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_op        <= '0;
      r_key       <= '0;
      r_val       <= '0;
      r_victim    <= '0;
      r_we        <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_val    <= '0;
      r_resp_flag <= '0;
      r_resp_val  <= '0;
      r_out_valid <= 1'b0;
      r_out_flag  <= '0;
      r_out_value <= '0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        StInit: r_cnt <= r_cnt + 1'b1;
        StIdle: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_idx <= in_hash[IDX_BITS-1:0];
            r_key <= in_key;
            r_val <= in_value;
            r_cnt <= '0;
          end
        end
        StLook: begin
          r_we        <= w_we_look;
          r_wr_valid  <= w_wr_valid_look;
          r_wr_val    <= w_wr_val_look;
          r_resp_flag <= w_flag_look;
          r_resp_val  <= w_val_look;
          if (w_victim_adv) r_victim <= r_victim + 1'b1;
        end
        StResp: begin
          r_out_valid <= 1'b1;
          r_out_flag  <= r_resp_flag;
          r_out_value <= r_resp_val;
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_flag  = r_out_flag;
  assign out_value = r_out_value;

endmodule

// File: tb/tb_db_cont_mw.sv
// Directed bench: an evicting and a rejecting table driven in lockstep by the same requests.
module tb_db_cont_mw;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = '0;
  logic [31:0] in_hash = '0;
  logic [95:0] in_key = '0;
  logic [31:0] in_value = '0;
  logic        rdy_e, rdy_r, ov_e, ov_r;
  logic [3:0]  fl_e, fl_r;
  logic [31:0] vl_e, vl_r;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  db_cont_mw #(.EVICT(1)) u_dut_ev (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_e), .in_op(in_op),
    .in_hash(in_hash), .in_key(in_key), .in_value(in_value),
    .out_valid(ov_e), .out_flag(fl_e), .out_value(vl_e)
  );

  db_cont_mw #(.EVICT(0)) u_dut_rj (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r), .in_op(in_op),
    .in_hash(in_hash), .in_key(in_key), .in_value(in_value),
    .out_valid(ov_r), .out_flag(fl_r), .out_value(vl_r)
  );

  localparam logic [31:0] H = 32'h11223344;

  function automatic logic [95:0] mk_key(input logic [15:0] dp);
    return {32'hC0A80A0B, 32'hC0A85057, 16'd12345, dp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Counts cycles with in_ready low starting at the current negedge; no response may appear.
  task automatic count_init(input string tag);
    int n = 0;
    bit saw_ov = 1'b0;
    while (!(rdy_e && rdy_r) && n < 1000) begin
      if (ov_e || ov_r) saw_ov = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'd256);
    chk({tag, "_no_resp"}, 32'(saw_ov), 32'd0);
    chk({tag, "_ready"}, {30'd0, rdy_e, rdy_r}, 32'd3);
  endtask

  task automatic accept(input logic [3:0] op, input logic [31:0] hash, input logic [95:0] key,
                        input logic [31:0] val);
    int n = 0;
    @(negedge clk);
    while (!(rdy_e && rdy_r) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {30'd0, rdy_e, rdy_r}, 32'd3);
    in_valid = 1'b1;
    in_op    = op;
    in_hash  = hash;
    in_key   = key;
    in_value = val;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = 4'b1010;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] hash,
                       input logic [95:0] key, input logic [31:0] val,
                       input logic [3:0] xf_e, input logic [31:0] xv_e,
                       input logic [3:0] xf_r, input logic [31:0] xv_r, input bit chk_val);
    accept(op, hash, key, val);
    chk({tag, "_ov_c0"}, {30'd0, ov_e, ov_r}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_ov_c1"}, {30'd0, ov_e, ov_r}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_ov_c2"}, {30'd0, ov_e, ov_r}, 32'd3);
    chk({tag, "_flag_ev"}, {28'd0, fl_e}, {28'd0, xf_e});
    chk({tag, "_flag_rj"}, {28'd0, fl_r}, {28'd0, xf_r});
    if (chk_val) begin
      chk({tag, "_val_ev"}, vl_e, xv_e);
      chk({tag, "_val_rj"}, vl_r, xv_r);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {30'd0, rdy_e, rdy_r}, 32'd0);
    chk("rst_ov", {30'd0, ov_e, ov_r}, 32'd0);
    chk("rst_flag", {24'd0, fl_e, fl_r}, 32'd0);
    chk("rst_val", vl_e | vl_r, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    count_init("init");

    do_op("get_empty", 4'b0000, H, mk_key(16'd80), 32'd0, 4'b0000, 0, 4'b0000, 0, 1);
    do_op("put_new", 4'b0011, H, mk_key(16'd80), 32'hDEADBEEF, 4'b0010, 0, 4'b0010, 0, 0);
    do_op("get_hit", 4'b0000, H, mk_key(16'd80), 32'd0,
          4'b0001, 32'hDEADBEEF, 4'b0001, 32'hDEADBEEF, 1);
    do_op("put_upd", 4'b0011, H, mk_key(16'd80), 32'h1,
          4'b0011, 32'hDEADBEEF, 4'b0011, 32'hDEADBEEF, 1);
    do_op("del_hit", 4'b0101, H, mk_key(16'd80), 32'd0, 4'b0001, 32'h1, 4'b0001, 32'h1, 1);
    do_op("del_miss", 4'b0101, H, mk_key(16'd80), 32'd0, 4'b0000, 0, 4'b0000, 0, 0);
    do_op("get_gone", 4'b0000, H, mk_key(16'd80), 32'd0, 4'b0000, 0, 4'b0000, 0, 1);

    for (int k = 1; k <= 4; k++)
      do_op($sformatf("fill%0d", k), 4'b0011, H, mk_key(16'(k)), 32'hA000_0000 + 32'(k),
            4'b0010, 0, 4'b0010, 0, 0);
    do_op("put_full", 4'b0011, H, mk_key(16'd5), 32'hA000_0005,
          4'b0110, 32'hA000_0001, 4'b1000, 0, 0);
    chk("evicted_val", vl_e, 32'hA000_0001);
    do_op("get_k1", 4'b0000, H, mk_key(16'd1), 32'd0, 4'b0000, 0, 4'b0001, 32'hA000_0001, 1);
    for (int k = 2; k <= 4; k++)
      do_op($sformatf("get_k%0d", k), 4'b0000, H, mk_key(16'(k)), 32'd0,
            4'b0001, 32'hA000_0000 + 32'(k), 4'b0001, 32'hA000_0000 + 32'(k), 1);
    do_op("get_k5", 4'b0000, H, mk_key(16'd5), 32'd0, 4'b0001, 32'hA000_0005, 4'b0000, 0, 1);
    do_op("hash_hi", 4'b0000, 32'hFFFF_FF44, mk_key(16'd2), 32'd0,
          4'b0001, 32'hA000_0002, 4'b0001, 32'hA000_0002, 1);
    do_op("illegal", 4'b0110, H, mk_key(16'd2), 32'h55, 4'b1000, 0, 4'b1000, 0, 1);
    do_op("after_ill", 4'b0000, H, mk_key(16'd2), 32'd0,
          4'b0001, 32'hA000_0002, 4'b0001, 32'hA000_0002, 1);

    accept(4'b1111, H, '0, '0);
    @(negedge clk);
    count_init("flush");
    for (int k = 2; k <= 5; k++)
      do_op($sformatf("flushed_k%0d", k), 4'b0000, H, mk_key(16'(k)), 32'd0,
            4'b0000, 0, 4'b0000, 0, 1);

    do_op("put_pre_rst", 4'b0011, H, mk_key(16'd7), 32'h77, 4'b0010, 0, 4'b0010, 0, 0);
    accept(4'b0000, H, mk_key(16'd7), '0);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_ready", {30'd0, rdy_e, rdy_r}, 32'd0);
    chk("midrst_flag", {24'd0, fl_e, fl_r}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_ov%0d", c), {30'd0, ov_e, ov_r}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    count_init("reinit");
    do_op("get_after_rst", 4'b0000, H, mk_key(16'd7), 32'd0, 4'b0000, 0, 4'b0000, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/db_cont_mw.md
Name: db_cont_mw

Overview:
- Parametrised successor of db_cont: N-way set-associative key/value table held in on-chip RAM, replacing the external-DRAM path.
- Sits between the packet parser (supplies hash/key/value/op) and the action logic (consumes flag/value).
- Adds ready/valid backpressure, a delete op, selectable eviction policy, post-reset table init, and a flush op.

Parameters:
HASH_SIZE, 32, in_hash width
KEY_SIZE, 96, key width
VAL_SIZE, 32, value width
FLAG_SIZE, 4, out_flag width (fixed 4 by encoding)
IDX_BITS, 8, bucket index bits; BUCKETS = 2**IDX_BITS
WAYS, 4, entries per bucket (power of two, >= 2)
EVICT, 1, 1 = round-robin replace when bucket full; 0 = reject with ERR

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronously released
in_valid  in  1  request valid
in_ready  out  1  block can accept request
in_op  in  4  0000 GET, 0011 PUT, 0101 DEL, 1111 FLUSH, others illegal
in_hash  in  HASH_SIZE  hash; index = in_hash[IDX_BITS-1:0]
in_key  in  KEY_SIZE  key
in_value  in  VAL_SIZE  value for PUT
out_valid  out  1  one-cycle response strobe
out_flag  out  FLAG_SIZE  [0] HIT, [1] WRITTEN, [2] EVICTED, [3] ERR
out_value  out  VAL_SIZE  response value

Behaviour:
- Reset (rst=0): state INIT, init counter 0, victim pointer 0, in_ready=0, out_valid=0, out_flag=0, out_value=0. Reset mid-operation aborts the op silently; no response.
- Entry = {valid, key, value}; per-way RAM with 1-cycle synchronous read, BUCKETS deep.
- FSM:
  - INIT: clear valid of bucket[cnt] in all ways, cnt++; after BUCKETS cycles -> IDLE. in_ready=0.
  - IDLE: in_ready=1. On in_valid: latch op/hash/key/value, issue read of all ways at index -> LOOK. FLUSH -> INIT without a response.
  - LOOK: compare all ways; hit = valid & key equal; lowest hit way wins. Compute write decision -> RESP.
  - RESP: perform RAM write, drive out_valid=1 for one cycle -> IDLE.
- Latency: out_valid two cycles after the accepting edge. Throughput one op per 3 cycles. in_ready=0 in LOOK/RESP/INIT.
- GET:
  - hit: HIT=1, out_value=stored value.
  - miss: flags 0, out_value=0.
- PUT:
  - hit: overwrite value in place; HIT=1, WRITTEN=1, out_value=old value.
  - miss, free way: write lowest-index invalid way; WRITTEN=1.
  - miss, bucket full, EVICT=1: write way = victim pointer, pointer+1 mod WAYS (global, advances only on eviction); WRITTEN=1, EVICTED=1, out_value=evicted value.
  - miss, bucket full, EVICT=0: no write; ERR=1.
- DEL:
  - hit: clear valid; HIT=1, out_value=deleted value.
  - miss: flags 0.
- Illegal op: no RAM access side-effect, ERR=1, out_value=0, same latency.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Outputs registered; out_flag/out_value hold last response when out_valid=0; cleared only by reset.
- Hash bits above IDX_BITS are ignored; key is compared in full width.

Decomposition:
- Package db_pkg: op encodings (OP_GET/OP_PUT/OP_DEL/OP_FLUSH), flag bit positions, FSM state enum, entry struct typedef.
- Sub-module db_way_ram: one way's single-port sync-read RAM (valid+key+value). Instantiated WAYS times via generate. Controller FSM, compare and victim logic stay in db_cont_mw.

Test Plan (K = {192.168.10.11, 192.168.80.87, 16'd12345}, hash 32'h11223344 -> idx 8'h44):
- Reset released -> in_ready low exactly 256 cycles, then high; GET K -> out_valid 2 cycles after accept, flag 4'b0000, value 0.
- PUT K val 32'hDEADBEEF -> flag 4'b0010. GET K -> flag 4'b0001, value DEADBEEF. PUT K val 32'h1 -> flag 4'b0011, value DEADBEEF.
- DEL K -> flag 4'b0001, value 32'h1. Second DEL K -> flag 0. GET K -> flag 0.
- EVICT=1: PUT 5 keys differing in dst_p, all hash idx 8'h44 -> 5th flag 4'b0110, value = 1st key's value. The 1st key now misses; keys 2-5 hit.
- EVICT=0: same stimulus -> 5th flag 4'b1000, no write, keys 1-4 still hit. Illegal op 4'b0110 -> flag 4'b1000.
- FLUSH after inserts -> no out_valid, in_ready low 256 cycles, all GETs miss. Assert rst during LOOK -> no out_valid, INIT restarts.
